binary_counter_dir: RTL and testbench
=====================================

BINARY_COUNTER_DIR -- requirements
Module: binary_counter_dir

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the counter width in bits (legal values 2 to 32).
REQ-002 The block SHALL have port clk, input, 1 bit, the single clock, with all state updating on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset (reset = 0 asserts it).
REQ-004 The block SHALL have port dir, input, 1 bit, the count direction: 1 = up, 0 = down.
REQ-005 The block SHALL have port count, output, WIDTH bits, the registered counter value.
REQ-006 The block SHALL have port at_max, output, 1 bit, high while count equals all-ones (2^WIDTH-1).
REQ-007 The block SHALL have port at_min, output, 1 bit, high while count equals 0.
REQ-008 The block SHALL have port wrap, output, 1 bit, a registered one-cycle pulse marking a wrap-around on the previous edge.

Function
REQ-009 On each rising clk edge with reset deasserted and dir = 1, count SHALL become (count + 1) mod 2^WIDTH.
REQ-010 On each rising clk edge with reset deasserted and dir = 0, count SHALL become (count - 1) mod 2^WIDTH.
REQ-011 The counter SHALL have no enable and no hold state: count changes by exactly 1 on every edge out of reset.
REQ-012 dir SHALL be sampled at the rising edge, and a dir change SHALL take effect on the first edge after the change, with no extra latency.
REQ-013 Up-count wrap SHALL go from all-ones to 0 (15 -> 0 for WIDTH = 4), with no saturation.
REQ-014 Down-count wrap SHALL go from 0 to all-ones (0 -> 15 for WIDTH = 4), with no saturation.
REQ-015 wrap SHALL be 1 for exactly the cycle following an edge on which count went from all-ones to 0 while counting up, or from 0 to all-ones while counting down; otherwise wrap SHALL be 0.
REQ-016 at_max and at_min SHALL be combinational decodes of the registered count, so they carry no extra latency relative to count.
REQ-017 Reversing direction at a boundary SHALL NOT wrap: at count = all-ones with dir = 0, the next value SHALL be all-ones - 1, and wrap SHALL be 0.
REQ-018 The outputs SHALL contain no combinational path from dir to count or to wrap.

Reset
REQ-019 When reset goes to 0, count SHALL clear to 0 immediately, independent of clk.
REQ-020 When reset goes to 0, wrap SHALL clear to 0 immediately, independent of clk.
REQ-021 While reset = 0, count SHALL hold at 0, wrap SHALL stay 0, at_min SHALL be 1 and at_max SHALL be 0.
REQ-022 The first rising edge after reset returns to 1 SHALL apply REQ-009/REQ-010 starting from count = 0.
REQ-023 Reset asserted mid-count SHALL discard the current value, with no pending wrap pulse surviving reset.

Verification
REQ-024 The bench SHALL cover power-up counting: reset = 0 for one cycle, then reset = 1 with dir = 1 for 16 edges -> count steps 1, 2, ... 15, 0; wrap = 1 only in the cycle after the 15 -> 0 edge.
REQ-025 The bench SHALL cover down-counting: from count = 15, dir = 0 for 16 edges -> count steps 14 ... 0, 15; wrap pulses once after the 0 -> 15 edge; at_min = 1 only while count = 0.
REQ-026 The bench SHALL cover a mid-cycle reset: reset pulsed to 0 between edges at count = 9 -> count reads 0 before the next clk edge, and wrap = 0.
REQ-027 The bench SHALL cover reversal at the top: count = 15 and dir switched to 0 -> next count 14, wrap stays 0; switching back to dir = 1 -> next count 15.
REQ-028 The bench SHALL cover the down-wrap out of reset: release reset with dir = 0 -> first edge gives count = 15, at_max = 1, and wrap = 1 in the following cycle.
REQ-029 The bench SHALL cover a parameter variant: WIDTH = 8, dir = 1 from 254 -> 255 then 0 with a wrap pulse; dir = 0 from 0 -> 255.

Source files
------------

// File: rtl/binary_counter_dir.sv
// Free-running up/down binary counter with boundary flags and a wrap pulse.
// The counter steps by exactly one on every clock edge. The step is up when
// dir is 1 and down when dir is 0. The counter wraps between all-ones and zero
// in both directions. wrap is registered. It is high for the one cycle that
// follows a wrap-around edge. at_max and at_min decode the registered count, so
// they line up with count in time.
module binary_counter_dir #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,    // asynchronous, active low
  input  logic             dir,      // 1 = count up, 0 = count down
  output logic [WIDTH-1:0] count,
  output logic             at_max,
  output logic             at_min,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] ALL_ONES = '1;
  localparam logic [WIDTH-1:0] ZERO     = '0;
  localparam logic [WIDTH-1:0] ONE      = WIDTH'(1);

  logic [WIDTH-1:0] count_reg;
  logic [WIDTH-1:0] count_next;
  logic             wrap_reg;
  logic             wrap_next;

  // Next count and wrap detection. A wrap happens only when the step crosses
  // the boundary in the current direction. Turning around at a boundary
  // steps back inward and does not wrap.
  always_comb begin
    count_next = count_reg;
    wrap_next  = 1'b0;
    if (dir) begin
      count_next = count_reg + ONE;
      wrap_next  = (count_reg == ALL_ONES);
    end else begin
      count_next = count_reg - ONE;
      wrap_next  = (count_reg == ZERO);
    end
  end

  // State register. Reset clears count and any pending wrap pulse at once,
  // without waiting for a clock edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= ZERO;
      wrap_reg  <= 1'b0;
    end else begin
      count_reg <= count_next;
      wrap_reg  <= wrap_next;
    end
  end

  assign count  = count_reg;
  assign wrap   = wrap_reg;
  assign at_max = (count_reg == ALL_ONES);
  assign at_min = (count_reg == ZERO);

endmodule

// File: tb/tb_binary_counter_dir.sv
// Self-checking bench for binary_counter_dir (WIDTH = 4 and WIDTH = 8 instances).
module tb_binary_counter_dir;

  logic       clk = 1'b0;
  logic       reset4, dir4, reset8, dir8;
  logic [3:0] count4;
  logic [7:0] count8;
  logic       at_max4, at_min4, wrap4;
  logic       at_max8, at_min8, wrap8;

  int checks = 0;
  int errors = 0;

  // Reference state: plain integer count plus the last wrap observation.
  int m4_count = 0, m8_count = 0;
  bit m4_wrap = 0, m8_wrap = 0;

  typedef struct {
    bit dir;
    int count;
    bit wrap;
  } vec_t;
  vec_t vecs[$];

  always #5 clk = ~clk;

  binary_counter_dir #(.WIDTH(4)) dut4 (
    .clk(clk), .reset(reset4), .dir(dir4),
    .count(count4), .at_max(at_max4), .at_min(at_min4), .wrap(wrap4)
  );

  binary_counter_dir #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset8), .dir(dir8),
    .count(count8), .at_max(at_max8), .at_min(at_min8), .wrap(wrap8)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Arithmetic model of one edge: step by +/-1 and fold back into [0, max].
  function automatic void model_edge(input bit rst_n, input bit d, input int max,
                                     inout int c, inout bit w);
    int n;
    if (!rst_n) begin
      c = 0;
      w = 0;
    end else begin
      n = c + (d ? 1 : -1);
      w = (n < 0) || (n > max);
      if (n < 0) n = n + max + 1;
      else if (n > max) n = n - (max + 1);
      c = n;
    end
  endfunction

  task automatic check_all(input string tag);
    check({tag, ".count4"},  count4,  m4_count);
    check({tag, ".wrap4"},   wrap4,   m4_wrap);
    check({tag, ".at_max4"}, at_max4, m4_count == 15);
    check({tag, ".at_min4"}, at_min4, m4_count == 0);
    check({tag, ".count8"},  count8,  m8_count);
    check({tag, ".wrap8"},   wrap8,   m8_wrap);
    check({tag, ".at_max8"}, at_max8, m8_count == 255);
    check({tag, ".at_min8"}, at_min8, m8_count == 0);
  endtask

  // One clock edge: model samples the inputs at the edge, DUT sampled 1ns later.
  task automatic tick(input string tag);
    @(posedge clk);
    model_edge(reset4, dir4, 15, m4_count, m4_wrap);
    model_edge(reset8, dir8, 255, m8_count, m8_wrap);
    #1;
    check_all(tag);
  endtask

  // Pulse reset4 low between edges. The count must clear before the next edge.
  task automatic mid_reset4(input string tag);
    #3;
    reset4 = 1'b0;
    m4_count = 0;
    m4_wrap  = 0;
    #1;
    check({tag, ".count"},  count4,  0);
    check({tag, ".wrap"},   wrap4,   0);
    check({tag, ".at_min"}, at_min4, 1);
    check({tag, ".at_max"}, at_max4, 0);
  endtask

  initial begin
    // Power-up, up-count table, one step down, then the down-count table.
    for (int i = 0; i < 16; i++) vecs.push_back(vec_t'{1'b1, (i + 1) % 16, i == 15});
    vecs.push_back(vec_t'{1'b0, 15, 1'b1});
    for (int i = 0; i < 15; i++) vecs.push_back(vec_t'{1'b0, 14 - i, 1'b0});
    vecs.push_back(vec_t'{1'b0, 15, 1'b1});

    reset4 = 1'b0; reset8 = 1'b0; dir4 = 1'b1; dir8 = 1'b1;
    #1;
    check_all("reset_async");
    tick("reset_hold");

    reset4 = 1'b1;
    foreach (vecs[i]) begin
      dir4 = vecs[i].dir;
      tick("table_model");
      check($sformatf("table[%0d].count", i),  count4,  vecs[i].count);
      check($sformatf("table[%0d].wrap", i),   wrap4,   vecs[i].wrap);
      check($sformatf("table[%0d].at_max", i), at_max4, vecs[i].count == 15);
      check($sformatf("table[%0d].at_min", i), at_min4, vecs[i].count == 0);
    end

    // Reversal at the top: 15 -> 14 with no wrap, then back up to 15.
    dir4 = 1'b0; tick("rev_down");
    check("rev_down.count", count4, 14);
    check("rev_down.wrap",  wrap4,  0);
    dir4 = 1'b1; tick("rev_up");
    check("rev_up.count", count4, 15);
    check("rev_up.wrap",  wrap4,  0);

    // Count up to 9 from 15, then reset between edges.
    for (int i = 0; i < 10; i++) tick("to_nine");
    check("to_nine.count", count4, 9);
    mid_reset4("mid_reset9");
    tick("reset_held");

    // Down-wrap right out of reset.
    dir4 = 1'b0; reset4 = 1'b1;
    tick("down_wrap");
    check("down_wrap.count",  count4,  15);
    check("down_wrap.at_max", at_max4, 1);
    check("down_wrap.wrap",   wrap4,   1);
    tick("down_after");
    check("down_after.count", count4, 14);
    check("down_after.wrap",  wrap4,  0);

    // An up-wrap pulse must not survive a reset.
    dir4 = 1'b1;
    tick("up15");
    tick("up_wrap");
    check("up_wrap.wrap", wrap4, 1);
    mid_reset4("reset_kills_wrap");
    reset4 = 1'b1;

    // WIDTH = 8 boundaries.
    reset8 = 1'b1; dir8 = 1'b0;
    tick("w8_down0");
    check("w8_down0.count", count8, 255);
    check("w8_down0.wrap",  wrap8,  1);
    tick("w8_254");
    check("w8_254.count", count8, 254);
    dir8 = 1'b1;
    tick("w8_255");
    check("w8_255.count",  count8,  255);
    check("w8_255.wrap",   wrap8,   0);
    check("w8_255.at_max", at_max8, 1);
    tick("w8_wrap");
    check("w8_wrap.count",  count8,  0);
    check("w8_wrap.wrap",   wrap8,   1);
    check("w8_wrap.at_min", at_min8, 1);
    dir8 = 1'b0;
    tick("w8_back");
    check("w8_back.count", count8, 255);
    check("w8_back.wrap",  wrap8,  1);

    // Random direction and occasional resets against the model.
    for (int i = 0; i < 400; i++) begin
      dir4 = 1'($urandom_range(0, 1));
      dir8 = 1'($urandom_range(0, 1));
      reset4 = ($urandom_range(0, 29) != 0);
      reset8 = ($urandom_range(0, 29) != 0);
      if (!reset4) begin m4_count = 0; m4_wrap = 0; end
      if (!reset8) begin m8_count = 0; m8_wrap = 0; end
      tick("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
